caravel_lcd_ctrl: RTL and testbench
===================================

# caravel_lcd_ctrl

Wishbone-attached controller for an HD44780-compatible character LCD in 4-bit mode, in the Caravel user project area and driven by management-core firmware. Firmware queues command and data bytes; the block produces the LCD bus timing (RS, E, D[7:4]) with fixed post-write waits. The block also drives a 6-bit firmware-written status field onto mprj_io[37:32] so a bench can follow progress: bit 5 is the error flag, bits 4:0 are the stage code.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles RS/D are stable before E rises.
- E_CYCLES, 20: E high width, and E low gap after each nibble.
- CMD_WAIT_CYCLES, 1480: wait after a normal byte (37 µs at 40 MHz).
- CLR_WAIT_CYCLES, 60800: wait after command 0x01/0x02/0x03 and after a raw nibble.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic strobes.
- wbs_sel_i  in  4  byte selects; only bit 0 is honoured.
- wbs_adr_i  in  32  address; only bits [4:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- lcd_rs, lcd_rw, lcd_e  out  1  LCD control; lcd_rw is always 0.
- lcd_d  out  4  LCD D[7:4].
- status_o  out  6  status field for mprj_io[37:32].

## Operation
Register map, word offsets:
- 0x00 DATA, write-only: enqueue {raw=0, rs=1, byte}.
- 0x04 CMD, write-only: enqueue {raw=0, rs=0, byte}.
- 0x08 STAT, read: bit0 busy (engine not idle or queue not empty), bit1 full, bit2 overflow (sticky). Writing 1 to bit2 clears overflow.
- 0x0C TEST, read/write: bits[5:0] drive status_o directly.
- 0x10 NIB, write-only: enqueue {raw=1, rs=0, nibble = dat[3:0]}. Used for the 4-bit initialisation sequence 3,3,3,2.

Register access rules:
- Writes apply only when wbs_sel_i[0]=1.
- Reads of unmapped or write-only offsets return 0.
- A write to DATA, CMD or NIB while the queue is full is discarded and sets overflow. It is still acknowledged.

Engine states: IDLE, SETUP_H, E_H, GAP_H, SETUP_L, E_L, GAP_L, WAIT.
- IDLE: if the queue is non-empty, pop an entry, drive lcd_rs and lcd_d = high nibble (or the raw nibble), and go to SETUP_H.
- SETUP_H (SETUP_CYCLES) -> E_H (lcd_e=1, E_CYCLES) -> GAP_H (lcd_e=0, E_CYCLES).
- After GAP_H: raw entry -> WAIT with CLR_WAIT_CYCLES; otherwise drive the low nibble and go to SETUP_L.
- SETUP_L -> E_L -> GAP_L use the same counts as the high-nibble phases.
- After GAP_L: go to WAIT. The wait is CLR_WAIT_CYCLES if rs=0 and the byte is 0x01, 0x02 or 0x03; otherwise CMD_WAIT_CYCLES.
- WAIT -> IDLE when the count expires.
- lcd_rs and lcd_d hold their values through WAIT; they are not returned to 0.
- One shared down-counter (17 bits minimum) times all states.

## Timing
- Reset: every output is 0, the queue is empty, overflow=0, the engine is in IDLE.
- Reset asserted mid-transfer aborts the transfer immediately; lcd_e falls on the same clock edge.
- Acknowledge:
  - wbs_ack_o rises one cycle after wbs_cyc_i & wbs_stb_i with ack low, and stays high for exactly 1 cycle, so back-to-back accesses take 2 cycles each.
  - Write effects and wbs_dat_o are valid in the ack cycle.
  - wbs_dat_o is 0 whenever ack is low.
- An enqueue in IDLE with an empty queue raises lcd_e exactly SETUP_CYCLES+2 cycles after the ack cycle.
- Byte duration, pop to IDLE: 2·SETUP_CYCLES + 4·E_CYCLES + wait, ±1 cycle per state transition. The implementation documents the exact count and the bench checks it.
- A simultaneous push and pop on a full queue is accepted with no overflow.
- Queue pointers wrap modulo the queue depth.

## Configuration
- LCD_FIFO_EN defined: the queue is a 4-entry FIFO of 10-bit entries {raw, rs, byte}.
- LCD_FIFO_EN undefined: the queue is a single holding register, and full = holding register occupied. The register map and the engine are unchanged.

## Test plan
- Reset, then read STAT and TEST -> both 0x0; lcd_e=0, status_o=0.
- Write TEST=0x1F, then TEST=0x00 -> status_o follows 31 then 0, each in the ack cycle. Write TEST=0x20 -> status_o[5]=1.
- CMD 0x28 -> lcd_rs=0 with lcd_d=0x2 on the first E pulse, then 0x8 on the second; each E pulse is E_CYCLES wide; busy clears after CMD_WAIT_CYCLES.
- DATA 'H' (0x48) -> lcd_rs=1 with nibbles 0x4 then 0x8. CMD 0x01 -> busy lasts at least CLR_WAIT_CYCLES after the second pulse.
- NIB writes 3,3,3,2 -> four single E pulses with lcd_d = 3,3,3,2, each followed by CLR_WAIT_CYCLES.
- Write the 17 bytes of "Hi, I'm Tholin :3" back-to-back:
  - With LCD_FIFO_EN: writes beyond the 4 queued plus 1 in flight set overflow (STAT=0x7); the bytes that were accepted appear in order on lcd_d.
  - Without LCD_FIFO_EN: overflow sets after 2 bytes.
  - Overflow clears on writing STAT=0x4.

Source files
------------

// File: rtl/caravel_lcd_ctrl.sv
// Wishbone-attached HD44780 4-bit LCD controller with a command queue and firmware status field.
// Define LCD_FIFO_EN for a 4-entry FIFO queue; otherwise a single holding register is used.
`timescale 1ns/1ps
module caravel_lcd_ctrl #(
  parameter int SETUP_CYCLES    = 2,
  parameter int E_CYCLES        = 20,
  parameter int CMD_WAIT_CYCLES = 1480,
  parameter int CLR_WAIT_CYCLES = 60800
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [3:0]  lcd_d,
  output logic [5:0]  status_o
);

  typedef enum logic [2:0] {IDLE, SETUP_H, E_H, GAP_H, SETUP_L, E_L, GAP_L, WAIT} state_t;

  state_t      state;
  logic [16:0] cnt;
  logic [9:0]  cur;
  logic        overflow;
  logic [5:0]  test_reg;

  logic        wb_req, wr_en, push_req, push, pop, busy, long_wait;
  logic [2:0]  reg_sel;
  logic [9:0]  push_data;
  logic        q_empty, q_full;
  logic [9:0]  q_head;
  logic        unused_bits;

  assign unused_bits = &{1'b0, wbs_sel_i[3:1], wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i[31:8]};

  assign lcd_rw    = 1'b0;
  assign status_o  = test_reg;
  assign reg_sel   = wbs_adr_i[4:2];
  assign wb_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_en     = wb_req & wbs_we_i & wbs_sel_i[0];
  assign push_req  = wr_en & ((reg_sel == 3'd0) | (reg_sel == 3'd1) | (reg_sel == 3'd4));
  assign pop       = (state == IDLE) & ~q_empty;
  assign push      = push_req & (~q_full | pop);
  assign busy      = (state != IDLE) | ~q_empty;
  assign long_wait = ~cur[8] & ((cur[7:0] == 8'h01) | (cur[7:0] == 8'h02) | (cur[7:0] == 8'h03));

  // Queue entries are {raw, rs, byte}; a raw nibble sits in byte[3:0].
  always_comb begin
    push_data = '0;
    case (reg_sel)
      3'd0:    push_data = {2'b01, wbs_dat_i[7:0]};
      3'd1:    push_data = {2'b00, wbs_dat_i[7:0]};
      3'd4:    push_data = {2'b10, 4'b0000, wbs_dat_i[3:0]};
      default: push_data = '0;
    endcase
  end

`ifdef LCD_FIFO_EN
  logic [9:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign q_empty = (count == 3'd0);
  assign q_full  = (count == 3'd4);
  assign q_head  = fifo_mem[rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic       hold_valid;
  logic [9:0] hold_data;

  assign q_empty = ~hold_valid;
  assign q_full  = hold_valid;
  assign q_head  = hold_data;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= push_data;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Register effects land on the same edge that raises ack, so they are visible in the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      overflow  <= 1'b0;
      test_reg  <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= '0;
      if (wb_req && !wbs_we_i) begin
        case (reg_sel)
          3'd2:    wbs_dat_o <= {29'd0, overflow, q_full, busy};
          3'd3:    wbs_dat_o <= {26'd0, test_reg};
          default: wbs_dat_o <= '0;
        endcase
      end
      if (push_req && !push)
        overflow <= 1'b1;
      else if (wr_en && reg_sel == 3'd2 && wbs_dat_i[2])
        overflow <= 1'b0;
      if (wr_en && reg_sel == 3'd3)
        test_reg <= wbs_dat_i[5:0];
    end
  end

  // Setup phases include the launch cycle: RS/D lead E by SETUP_CYCLES+1 cycles, and a full
  // byte takes 2*SETUP_CYCLES + 4*E_CYCLES + wait + 2 cycles from pop to IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      cur    <= '0;
      lcd_rs <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_d  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cur    <= q_head;
            lcd_rs <= q_head[8];
            lcd_d  <= q_head[9] ? q_head[3:0] : q_head[7:4];
            cnt    <= 17'(SETUP_CYCLES);
            state  <= SETUP_H;
          end
        end
        SETUP_H, SETUP_L: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= 17'(E_CYCLES - 1);
            state <= (state == SETUP_H) ? E_H : E_L;
          end else cnt <= cnt - 17'd1;
        end
        E_H, E_L: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= 17'(E_CYCLES - 1);
            state <= (state == E_H) ? GAP_H : GAP_L;
          end else cnt <= cnt - 17'd1;
        end
        GAP_H: begin
          if (cnt == '0) begin
            if (cur[9]) begin
              cnt   <= 17'(CLR_WAIT_CYCLES - 1);
              state <= WAIT;
            end else begin
              lcd_d <= cur[3:0];
              cnt   <= 17'(SETUP_CYCLES);
              state <= SETUP_L;
            end
          end else cnt <= cnt - 17'd1;
        end
        GAP_L: begin
          if (cnt == '0) begin
            cnt   <= long_wait ? 17'(CLR_WAIT_CYCLES - 1) : 17'(CMD_WAIT_CYCLES - 1);
            state <= WAIT;
          end else cnt <= cnt - 17'd1;
        end
        WAIT: begin
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 17'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caravel_lcd_ctrl.sv
// Self-checking bench for caravel_lcd_ctrl: a per-cycle waveform model expanded from queued
// entries, directed literal checks, and randomized register traffic.
`timescale 1ns/1ps
module tb_caravel_lcd_ctrl;

  localparam int S    = 2;
  localparam int E    = 3;
  localparam int CMDW = 20;
  localparam int CLRW = 40;
`ifdef LCD_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_i  = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i  = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        lcd_rs, lcd_rw, lcd_e;
  logic [3:0]  lcd_d;
  logic [5:0]  status_o;

  caravel_lcd_ctrl #(
    .SETUP_CYCLES(S), .E_CYCLES(E), .CMD_WAIT_CYCLES(CMDW), .CLR_WAIT_CYCLES(CLRW)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d),
    .status_o(status_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: queued entries, and the per-cycle {e, rs, d} samples of the entry being sent.
  logic [9:0] pend[$];
  logic [5:0] wave[$];
  logic [5:0] m_out  = '0;
  logic       m_ack  = 1'b0;
  logic [31:0] m_dat = '0;
  logic       m_ovf  = 1'b0;
  logic [5:0] m_test = '0;
  bit         model_valid = 0;

  function automatic void addPulse(input logic rs, input logic [3:0] n);
    repeat (S + 1) wave.push_back({1'b0, rs, n});
    repeat (E)     wave.push_back({1'b1, rs, n});
    repeat (E)     wave.push_back({1'b0, rs, n});
  endfunction

  // Enqueue-to-E latency of S+2 cycles means data leads E by S+1 cycles; one idle cycle follows the wait.
  function automatic void expandEntry(input logic [9:0] ent);
    logic       raw, rs;
    logic [7:0] b;
    logic [3:0] hi, last;
    int         w;
    raw = ent[9];
    rs  = ent[8];
    b   = ent[7:0];
    hi  = raw ? b[3:0] : b[7:4];
    addPulse(rs, hi);
    if (raw) begin
      w    = CLRW;
      last = hi;
    end else begin
      addPulse(rs, b[3:0]);
      w    = (!rs && b >= 8'd1 && b <= 8'd3) ? CLRW : CMDW;
      last = b[3:0];
    end
    repeat (w + 1) wave.push_back({1'b0, rs, last});
  endfunction

  always @(posedge wb_clk_i) begin
    logic        req, eng_busy;
    logic [2:0]  rsel;
    logic [9:0]  ent;
    if (wb_rst_i) begin
      pend.delete();
      wave.delete();
      m_out = '0; m_ack = 1'b0; m_dat = '0; m_ovf = 1'b0; m_test = '0;
      model_valid = 1;
    end else begin
      req      = wbs_cyc_i & wbs_stb_i & !m_ack;
      eng_busy = (wave.size() != 0);
      rsel     = wbs_adr_i[4:2];
      m_dat    = '0;
      if (req && !wbs_we_i) begin
        if (rsel == 3'd2)
          m_dat = {29'd0, m_ovf, pend.size() == CAP, eng_busy || pend.size() != 0};
        else if (rsel == 3'd3)
          m_dat = {26'd0, m_test};
      end
      if (wave.size() != 0) m_out = wave.pop_front();
      else if (pend.size() != 0) begin
        expandEntry(pend.pop_front());
        m_out = wave.pop_front();
      end
      if (req && wbs_we_i && wbs_sel_i[0]) begin
        if (rsel == 3'd0 || rsel == 3'd1 || rsel == 3'd4) begin
          if (rsel == 3'd0)      ent = {2'b01, wbs_dat_i[7:0]};
          else if (rsel == 3'd1) ent = {2'b00, wbs_dat_i[7:0]};
          else                   ent = {2'b10, 4'd0, wbs_dat_i[3:0]};
          if (pend.size() < CAP) pend.push_back(ent);
          else m_ovf = 1'b1;
        end else if (rsel == 3'd2 && wbs_dat_i[2]) m_ovf = 1'b0;
        else if (rsel == 3'd3) m_test = wbs_dat_i[5:0];
      end
      m_ack = req;
    end
  end

  always @(negedge wb_clk_i) begin
    if (model_valid) begin
      checkOutput("lcd_e",     32'(lcd_e),    32'(m_out[5]));
      checkOutput("lcd_rs",    32'(lcd_rs),   32'(m_out[4]));
      checkOutput("lcd_d",     32'(lcd_d),    32'(m_out[3:0]));
      checkOutput("lcd_rw",    32'(lcd_rw),   32'd0);
      checkOutput("wbs_ack_o", 32'(wbs_ack_o), 32'(m_ack));
      checkOutput("wbs_dat_o", wbs_dat_o,     m_dat);
      checkOutput("status_o",  32'(status_o), 32'(m_test));
    end
  end

  // Record {rs, d} at every rising edge of E.
  logic [4:0] seen[$];
  logic       prev_e = 1'b0;
  always @(negedge wb_clk_i) begin
    if (lcd_e === 1'b1 && prev_e === 1'b0) seen.push_back({lcd_rs, lcd_d});
    prev_e = lcd_e;
  end

  // Bus tasks start and end at posedge+1.
  task automatic applyStimulus(input logic w, input logic [2:0] r, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] rdata, output logic [5:0] st);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = {27'd0, r, 2'b00}; wbs_dat_i = d; wbs_sel_i = s;
    @(posedge wb_clk_i); #1;
    rdata = wbs_dat_o;
    st    = status_o;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wbWrite(input logic [2:0] r, input logic [31:0] d);
    logic [31:0] x;
    logic [5:0]  y;
    applyStimulus(1'b1, r, d, 4'hF, x, y);
  endtask

  task automatic wbRead(input logic [2:0] r, output logic [31:0] rd);
    logic [5:0] y;
    applyStimulus(1'b0, r, 32'd0, 4'hF, rd, y);
  endtask

  task automatic waitRise(input int budget, output int n, output bit ok);
    n = 0; ok = 0;
    while (n < budget) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (lcd_e === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic waitFall(input int budget, output int width);
    width = 0;
    while (width < budget) begin
      @(posedge wb_clk_i); #1;
      width++;
      if (lcd_e !== 1'b1) break;
    end
  endtask

  task automatic waitIdle(input int budget);
    int n;
    logic [31:0] rd;
    n = 0;
    while ((pend.size() != 0 || wave.size() != 0) && n < budget) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    wbRead(3'd2, rd);
    checkOutput("stat_idle", 32'(rd[0]), 32'd0);
  endtask

  // One entry from idle: latency, nibbles, pulse widths and the exact end of busy.
  task automatic testByte(input logic [2:0] r, input logic [7:0] b, input bit raw, input bit longw);
    int n, w, wt;
    bit ok;
    logic [31:0] rd;
    wbWrite(r, 32'(b));
    waitRise(200, n, ok);
    checkOutput("e_rise_hi", 32'(ok), 32'd1);
    checkOutput("e_latency", 32'(n + 1), 32'(S + 2));
    checkOutput("rs_hi", 32'(lcd_rs), (r == 3'd0) ? 32'd1 : 32'd0);
    checkOutput("d_hi", 32'(lcd_d), raw ? 32'(b[3:0]) : 32'(b[7:4]));
    waitFall(200, w);
    checkOutput("e_width_hi", 32'(w), 32'(E));
    if (!raw) begin
      waitRise(200, n, ok);
      checkOutput("e_rise_lo", 32'(ok), 32'd1);
      checkOutput("d_lo", 32'(lcd_d), 32'(b[3:0]));
      waitFall(200, w);
      checkOutput("e_width_lo", 32'(w), 32'(E));
    end
    wt = (raw || longw) ? CLRW : CMDW;
    repeat (E + wt - 2) @(posedge wb_clk_i);
    #1;
    wbRead(3'd2, rd);
    checkOutput("busy_in_wait", 32'(rd[0]), 32'd1);
    wbRead(3'd2, rd);
    checkOutput("busy_after_wait", 32'(rd[0]), 32'd0);
  endtask

  string msg = "Hi, I'm Tholin :3";

  initial begin
    logic [31:0] rd;
    logic [5:0]  st;
    int          n, g, op;
    bit          ok;
    logic [31:0] d;
    logic [3:0]  s;
    logic [3:0]  nibs [4];

    repeat (3) @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;

    wbRead(3'd2, rd);
    checkOutput("reset_stat", rd, 32'd0);
    wbRead(3'd3, rd);
    checkOutput("reset_test", rd, 32'd0);
    checkOutput("reset_lcd_e", 32'(lcd_e), 32'd0);
    checkOutput("reset_status", 32'(status_o), 32'd0);

    applyStimulus(1'b1, 3'd3, 32'h1F, 4'hF, rd, st);
    checkOutput("test_1f", 32'(st), 32'd31);
    applyStimulus(1'b1, 3'd3, 32'h00, 4'hF, rd, st);
    checkOutput("test_00", 32'(st), 32'd0);
    applyStimulus(1'b1, 3'd3, 32'h20, 4'hF, rd, st);
    checkOutput("test_err_bit", 32'(st[5]), 32'd1);
    wbWrite(3'd3, 32'h0);

    testByte(3'd1, 8'h28, 1'b0, 1'b0);
    testByte(3'd0, 8'h48, 1'b0, 1'b0);
    testByte(3'd1, 8'h01, 1'b0, 1'b1);

    nibs[0] = 4'd3; nibs[1] = 4'd3; nibs[2] = 4'd3; nibs[3] = 4'd2;
    for (int i = 0; i < 4; i++) testByte(3'd4, {4'd0, nibs[i]}, 1'b1, 1'b1);

    seen.delete();
    for (int i = 0; i < 17; i++) wbWrite(3'd0, 32'(msg[i]));
    wbRead(3'd2, rd);
    checkOutput("burst_stat", rd, 32'h7);
    wbWrite(3'd2, 32'h4);
    wbRead(3'd2, rd);
    checkOutput("ovf_cleared", 32'(rd[2]), 32'd0);
    waitIdle(4000);
    checkOutput("burst_nibbles", 32'(seen.size()), 32'(2 * (CAP + 1)));
    for (int i = 0; i < CAP + 1; i++) begin
      if (2 * i + 1 < seen.size()) begin
        checkOutput("burst_byte", 32'({seen[2*i][3:0], seen[2*i+1][3:0]}), 32'(msg[i]));
        checkOutput("burst_rs", 32'(seen[2*i][4]), 32'd1);
      end
    end

    wbWrite(3'd1, 32'h28);
    wbWrite(3'd0, 32'h41);
    waitRise(200, n, ok);
    checkOutput("abort_rise", 32'(ok), 32'd1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    checkOutput("abort_e_low", 32'(lcd_e), 32'd0);
    checkOutput("abort_d_zero", 32'(lcd_d), 32'd0);
    wb_rst_i = 1'b0;
    wbRead(3'd2, rd);
    checkOutput("abort_stat", rd, 32'd0);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      d  = $urandom;
      s  = ($urandom_range(0, 7) == 0) ? 4'hE : 4'hF;
      case (op)
        0, 1, 2: applyStimulus(1'b1, 3'd0, d, s, rd, st);
        3, 4: begin
          if ($urandom_range(0, 2) == 0) d = 32'($urandom_range(1, 3));
          applyStimulus(1'b1, 3'd1, d, s, rd, st);
        end
        5: applyStimulus(1'b1, 3'd4, d, s, rd, st);
        6: applyStimulus(1'b0, 3'd2, d, s, rd, st);
        7: applyStimulus(1'b1, 3'd3, d, s, rd, st);
        8: applyStimulus(1'b1, 3'd2, d, s, rd, st);
        default: applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), d, s, rd, st);
      endcase
      g = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(0, 3);
      if (g > 0) begin
        repeat (g) @(posedge wb_clk_i);
        #1;
      end
    end
    waitIdle(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
